// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between NUM_REQ requesters.
// Accesses are serialised through an IDLE -> ACCESS -> RESP FSM; the winner
// sees grant during ACCESS and done (with read data) during RESP.
// Build option: define DMEM_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins, no rotating pointer); default is round-robin.
module dmem_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 12
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               req,
   input  logic [NUM_REQ-1:0]               req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
   output logic [NUM_REQ-1:0]               grant,
   output logic [NUM_REQ-1:0]               done,
   output logic [DATA_WIDTH-1:0]            rdata,
   output logic                             busy,
   output logic [ADDR_WIDTH-1:0]            mem_addr,
   output logic [DATA_WIDTH-1:0]            mem_data,
   output logic                             mem_wren,
   input  logic [DATA_WIDTH-1:0]            mem_q
);

   localparam int PTR_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t                  state, state_nxt;
   logic [PTR_W-1:0]        win_q, win_nxt;      // requester being served
   logic                    we_q, we_nxt;        // served access is a write
   logic [PTR_W-1:0]        sel_idx;
   logic                    sel_valid;
   logic [NUM_REQ-1:0]      grant_nxt, done_nxt;
   logic                    busy_nxt, wren_nxt;
   logic [ADDR_WIDTH-1:0]   addr_nxt;
   logic [DATA_WIDTH-1:0]   data_nxt;

`ifndef DMEM_ARB_FIXED_PRIO_EN
   logic [PTR_W-1:0]        ptr, ptr_nxt;
`endif

   // Winner selection: scan from the highest search position down so the
   // first requester in search order is the last one written.
   always_comb begin
      logic [PTR_W-1:0] cand;
      sel_valid = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
         cand = PTR_W'(k);
`else
         cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
`endif
         if (req[cand]) begin
            sel_valid = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   // Next-state and next-output logic for the access FSM.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      state_nxt = state;
      win_nxt   = win_q;
      we_nxt    = we_q;
      grant_nxt = '0;
      done_nxt  = '0;
      wren_nxt  = 1'b0;
      addr_nxt  = mem_addr;
      data_nxt  = mem_data;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      ptr_nxt   = ptr;
`endif
      case (state)
         IDLE, RESP: begin
            if (sel_valid) begin
               state_nxt          = ACCESS;
               win_nxt            = sel_idx;
               we_nxt             = req_we[sel_idx];
               grant_nxt[sel_idx] = 1'b1;
               wren_nxt           = req_we[sel_idx];
               addr_nxt           = req_addr[int'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
               data_nxt           = req_wdata[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
`ifndef DMEM_ARB_FIXED_PRIO_EN
               ptr_nxt = (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
`endif
            end else begin
               state_nxt = IDLE;
            end
         end
         ACCESS: begin
            state_nxt       = RESP;
            done_nxt[win_q] = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Registered outputs and per-access bookkeeping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         win_q    <= '0;
         we_q     <= 1'b0;
         grant    <= '0;
         done     <= '0;
         busy     <= 1'b0;
         mem_addr <= '0;
         mem_data <= '0;
         mem_wren <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
         ptr      <= '0;
`endif
      end else begin
         win_q    <= win_nxt;
         we_q     <= we_nxt;
         grant    <= grant_nxt;
         done     <= done_nxt;
         busy     <= busy_nxt;
         mem_addr <= addr_nxt;
         mem_data <= data_nxt;
         mem_wren <= wren_nxt;
`ifndef DMEM_ARB_FIXED_PRIO_EN
         ptr      <= ptr_nxt;
`endif
      end
   end

   // Read data passes straight from the memory during RESP of a read only.
   assign rdata = (state == RESP && !we_q) ? mem_q : '0;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Round-robin arbiter that shares the single-port 12-bit data memory between up to NUM_REQ requesters, such as several processor cores, or a core plus a program loader. It sits between the requesters' memory ports and the memory's address/data/wren/q pins. It serialises accesses through a three-state FSM and returns a one-cycle completion pulse with read data.

## Interface
- NUM_REQ, 4: number of requesters; must be at least 2.
- ADDR_WIDTH, 12: memory address width.
- DATA_WIDTH, 12: memory data width.
- clk, input, 1: clock. All state changes on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- req, input, NUM_REQ: per-requester access request.
- req_we, input, NUM_REQ: per-requester access type. 1 = write, 0 = read.
- req_addr, input, NUM_REQ*ADDR_WIDTH: packed addresses. Requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata, input, NUM_REQ*DATA_WIDTH: packed write data, packed the same way as req_addr.
- grant, output, NUM_REQ: one-hot. High for exactly one cycle (ACCESS) for the selected requester.
- done, output, NUM_REQ: one-hot. High for exactly one cycle (RESP) for the requester being served.
- rdata, output, DATA_WIDTH: read data. Valid only while done is high for a read; 0 at all other times.
- busy, output, 1: high when the FSM is not in IDLE.
- mem_addr, output, ADDR_WIDTH: registered address to the memory.
- mem_data, output, DATA_WIDTH: registered write data to the memory.
- mem_wren, output, 1: registered write enable to the memory.
- mem_q, input, DATA_WIDTH: memory read data, available one cycle after the address is presented.

## Operation
- FSM states are IDLE, ACCESS and RESP.
- **IDLE**
  - If any req is high, select a winner, register its address, data and write type onto the mem_* outputs, and go to ACCESS.
  - Otherwise, stay in IDLE.
- **ACCESS**
  - grant[winner] is high.
  - mem_wren is high only if req_we[winner] was high when the winner was selected.
  - The memory captures the address and data at the end of this cycle.
  - The next state is always RESP.
- **RESP**
  - done[winner] is high.
  - For reads, rdata equals mem_q; for writes, rdata is 0.
  - mem_wren is low.
  - If any req is high, arbitrate again exactly as in IDLE and go to ACCESS. Otherwise go to IDLE.
- **Requester contract**
  - Hold req, req_we, req_addr and req_wdata stable from assertion until grant is seen.
  - Deassert req on the edge that ends ACCESS, or keep it high to request another access.
  - The arbiter does not sample a requester's inputs after its grant cycle.
- **Round-robin arbitration**
  - A pointer ptr (width log2 NUM_REQ) selects the winner: the first index with req high, searching ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1.
  - On selection, ptr becomes winner+1, wrapping from NUM_REQ-1 to 0.
  - ptr resets to 0.
- **Reset values:** state = IDLE, ptr = 0, and grant, done, rdata, busy, mem_addr, mem_data and mem_wren all 0.
- **Boundary cases**
  - All req high every cycle: grants rotate 0, 1, 2, 3, 0, …
  - A requester keeping req high is served again only after every other pending requester has been served.
  - A req arriving during ACCESS is first considered in RESP.
  - Reset asserted mid-ACCESS forces mem_wren low immediately. Whether that write lands is undefined, and no done is issued.

## Timing
- Latency from req first sampled high in IDLE:
  - grant is high 1 cycle later.
  - done and rdata are high 2 cycles later.
- Back-to-back throughput is one access every 2 cycles (ACCESS, RESP, ACCESS, …) with no IDLE gap.
- rdata is a combinational mux from mem_q during RESP. All other outputs are registered.
- grant and done are never both high for the same requester in the same cycle.

## Configuration
- DMEM_ARB_FIXED_PRIO_EN
  - Defined: fixed priority. The lowest index with req high always wins, and ptr is removed.
  - Undefined (default): round-robin arbitration as described above.
  - Timing and the FSM are identical in both cases.

## Test plan
- **Reset:** hold reset = 0 with random req. All outputs must stay 0. Release: busy = 0 until a req is applied.
- **Single read:** memory preloaded with 0x5A3 at address 0x010. req[2] = 1, read of address 0x010. Required: grant = 4'b0100 at T+1; done = 4'b0100 and rdata = 0x5A3 at T+2.
- **Write then read:** requester 1 writes 0xABC to address 0x0FF, then reads it back. Required: mem_wren = 1 only during the write's ACCESS cycle; the read returns 0xABC.
- **Round-robin contention:** req = 4'b1111 held for 16 cycles. Required: grant sequence 0001, 0010, 0100, 1000 repeating, with a gap of exactly 2 cycles between grants. Under DMEM_ARB_FIXED_PRIO_EN, grant must be 0001 every time.
- **Late arrival and wrap:** ptr = 3 with req[3] low. Assert req[0] and req[3] together. Required: requester 3 wins, then requester 0.
- **Reset mid-access:** pull reset low during ACCESS. Required: mem_wren and grant drop within the same cycle, with no done afterwards; after release, state is IDLE and ptr = 0.
